font_rom_arbiter: RTL
=====================

Name: font_rom_arbiter

Overview:
- Shares the single synchronous font ROM (11-bit address, 8-bit row word) among up to NUM_REQ text-painting requesters, e.g. digit field, state label, title banner, cursor.
- Arbitrates each cycle, drives the ROM address, and routes the returning font row back to the requester that issued it, tagged by a latency-matched pipeline.
- Sits between the text painters and the font ROM in the VGA monitor path; it is the controller for the font_word/rom_addr datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 11, font ROM address width: {char_code[6:0], row[3:0]}.
- DATA_W, 8, font row width.
- ROM_LAT, 1, ROM read latency in cycles from registered rom_addr to valid rom_data (1..3).

Ports:
- clk  in  1  pixel/system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester read request; held with its address until granted.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; slice i belongs to req[i].
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as the winning req.
- rom_addr  out  ADDR_W  registered address to the font ROM.
- rom_data  in  DATA_W  font ROM read data (the font_word source).
- rsp_valid  out  NUM_REQ  one-hot pulse; rsp_data is valid for this requester.
- rsp_data  out  DATA_W  returned font row, pass-through of rom_data.
- busy  out  1  high while any ROM read is in flight.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - rom_addr=0, rsp_valid=0, busy=0, gnt forced to 0.
  - Round-robin pointer rr_ptr=0; all tag pipeline valid bits cleared.
- Arbitration, cycle t:
  - Winner is the first i with req[i]=1, scanning circularly from rr_ptr.
  - gnt[winner]=1; at most one gnt bit is set.
  - No req set: gnt=0, rr_ptr unchanged, rom_addr holds its last value.
- Address issue, t+1:
  - rom_addr <= req_addr slice of the winner.
  - rr_ptr <= (winner+1) mod NUM_REQ.
- Response, t+1+ROM_LAT:
  - rsp_valid[winner]=1 for exactly one cycle; rsp_data=rom_data.
  - With ROM_LAT=1 this is grant t, address t+1, data t+2.
- Throughput: one grant per cycle, fully pipelined. Up to ROM_LAT+1 reads in flight, each carrying its own {valid, index} tag through a ROM_LAT+1 deep shift register.
- busy = OR of the tag valid bits.
- Requester rules:
  - A requester may drop req before being granted; nothing is issued for it.
  - A requester holding req continuously while others request is granted within NUM_REQ cycles.
  - req_addr changing while ungranted is allowed; the address sampled is the one present in the grant cycle.
- Simultaneous responses cannot occur (one issue per cycle). rsp_valid is all-zero when no tag exits the pipeline.
- Reset mid-operation: in-flight tags are discarded. No rsp_valid pulse appears after rst_n deasserts for reads granted before reset.
- rsp_data while rsp_valid=0 is don't-care, but must not be X under simulation once the ROM has been read.

Optional Feature:
- Macro: FONT_ARB_PRIORITY_EN.
- Defined: requester 0 (the live pixel pipeline) has fixed absolute priority. Whenever req[0]=1 it wins. Remaining requesters are round-robin among themselves. rr_ptr advances only on grants to indices 1..NUM_REQ-1 and skips index 0.
- Undefined: pure round-robin across all NUM_REQ requesters as described above.

Decomposition:
- Package font_pkg holds:
  - FONT_ADDR_W=11, FONT_DATA_W=8, CHAR_W=7, ROW_W=4.
  - Function font_addr(char, row) returning {char, row}.
  - Tag struct type {logic valid; logic [2:0] idx}.
- Sub-module rr_pick: a combinational circular priority encoder (req vector, pointer in; one-hot grant and binary index out). It is reused by the priority variant, which masks bit 0.

Test Plan:
- Reset then idle, no req: gnt=0, rsp_valid=0, busy=0, and rom_addr stays 0 for 20 cycles.
- Single requester, req=0010, addr 0x2A3 at cycle 5: gnt=0010 at 5, rom_addr=0x2A3 at 6, rsp_valid=0010 at 7 with rsp_data equal to the ROM model word for 0x2A3.
- All four requesting continuously with distinct addresses 0x010/0x020/0x030/0x040: grants rotate 0,1,2,3,0… one per cycle. rsp_valid pulses follow the same order 2 cycles later with matching data. No index waits more than 4 cycles.
- req[2] dropped one cycle before its turn with rr_ptr=2: grant goes to 3, and nothing is ever returned to 2.
- Reset pulsed while 2 reads are in flight (ROM_LAT=2): no rsp_valid after release, busy=0, and the first post-reset grant goes to the lowest requesting index.
- FONT_ARB_PRIORITY_EN defined, req=1111 held: req 0 granted every cycle and others starve. Then req=1110: grants rotate 1,2,3 and rr_ptr never lands on 0.

Source files
------------

// File: rtl/font_pkg.sv
// Shared font ROM geometry, address helper and the read tag carried alongside each ROM access.
package font_pkg;

  localparam int FONT_ADDR_W = 11;
  localparam int FONT_DATA_W = 8;
  localparam int CHAR_W      = 7;
  localparam int ROW_W       = 4;
  localparam int IDX_W       = 3;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

  function automatic logic [FONT_ADDR_W-1:0] font_addr(input logic [CHAR_W-1:0] ch,
                                                       input logic [ROW_W-1:0]  row);
    return {ch, row};
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Circular priority encoder: first set bit of req at or after ptr, wrapping at N.
module rr_pick
  import font_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  int j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/font_rom_arbiter.sv
// Round-robin arbiter sharing one font ROM; returns each row to its requester via a tag pipeline.
// Build option FONT_ARB_PRIORITY_EN gives requester 0 fixed absolute priority.
module font_rom_arbiter
  import font_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = FONT_ADDR_W,
  parameter int DATA_W  = FONT_DATA_W,
  parameter int ROM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy
);

  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   ptr_nxt;
  logic [NUM_REQ-1:0] pick_req;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  logic               win_valid;
  logic [IDX_W-1:0]   win_idx;
  tag_t               tag_q [ROM_LAT+1];

`ifdef FONT_ARB_PRIORITY_EN
  assign pick_req = {req[NUM_REQ-1:1], 1'b0};
`else
  assign pick_req = req;
`endif

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (pick_req),
    .ptr   (rr_ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
`ifdef FONT_ARB_PRIORITY_EN
    if (req[0]) begin
      win_valid = 1'b1;
    end else if (pick_found) begin
      win_valid = 1'b1;
      win_idx   = pick_idx;
    end
`else
    if (pick_found) begin
      win_valid = 1'b1;
      win_idx   = pick_idx;
    end
`endif
    // Grant is held off while reset is asserted even though it is combinational.
    gnt = (rst_n && win_valid) ? pick_gnt_or_zero(win_idx) : '0;
  end

  function automatic logic [NUM_REQ-1:0] pick_gnt_or_zero(input logic [IDX_W-1:0] i);
    return ONE << i;
  endfunction

  always_comb begin
    ptr_nxt = rr_ptr;
`ifdef FONT_ARB_PRIORITY_EN
    // Pointer only moves on grants to 1..NUM_REQ-1 and never rests on index 0.
    if (win_valid && win_idx != '0)
      ptr_nxt = (int'(win_idx) == NUM_REQ-1) ? IDX_W'(1) : win_idx + IDX_W'(1);
`else
    if (win_valid)
      ptr_nxt = (int'(win_idx) == NUM_REQ-1) ? '0 : win_idx + IDX_W'(1);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      rom_addr <= '0;
      for (int k = 0; k <= ROM_LAT; k++) tag_q[k] <= '0;
    end else begin
      rr_ptr <= ptr_nxt;
      if (win_valid) rom_addr <= req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
      tag_q[0] <= '{valid: win_valid, idx: win_idx};
      for (int k = 1; k <= ROM_LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  // The last tag stage lines up with the cycle rom_data carries that read's row.
  assign rsp_valid = tag_q[ROM_LAT].valid ? (ONE << tag_q[ROM_LAT].idx) : '0;
  assign rsp_data  = rom_data;

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k <= ROM_LAT; k++) busy = busy | tag_q[k].valid;
  end

endmodule
